// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: FSM encodings, default widths
// and the MEM/WB bubble constant.
package mem_stage_ctrl_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int WN_W_DEF    = 5;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_CTRL_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register: holds when load=0, takes a bubble (all zero) when
// bubble=1, otherwise captures the selected writeback fields.
module mem_wb_reg
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WN_W   = WN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  wb_ctrl_t          ctrl_in,
  input  logic [DATA_W-1:0] rd_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [WN_W-1:0]   wn_in,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] RD_out,
  output logic [DATA_W-1:0] ALU_out,
  output logic [WN_W-1:0]   WN_out
);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || (load && bubble)) begin
      RegWrite_out <= WB_CTRL_BUBBLE.reg_write;
      MemtoReg_out <= WB_CTRL_BUBBLE.mem_to_reg;
      RD_out       <= '0;
      ALU_out      <= '0;
      WN_out       <= '0;
    end else if (load) begin
      RegWrite_out <= ctrl_in.reg_write;
      MemtoReg_out <= ctrl_in.mem_to_reg;
      RD_out       <= rd_in;
      ALU_out      <= alu_in;
      WN_out       <= wn_in;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: decodes loads/stores, runs the req/ack data-memory access,
// stalls upstream while it is outstanding. Optional `ALIGN_CHECK_EN rejects misaligned accesses.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int WN_W    = WN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic [DATA_W-1:0] ALU_in,
  input  logic [DATA_W-1:0] RD2_in,
  input  logic [WN_W-1:0]   WN_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              mem_err,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] RD_out,
  output logic [DATA_W-1:0] ALU_out,
  output logic [WN_W-1:0]   WN_out
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  wb_ctrl_t          lat_ctrl, in_ctrl, wb_ctrl;
  logic [WN_W-1:0]   lat_wn;
  logic              lat_read;
  logic              acc, conflict, misaligned, issue, done, abort, align_err;
  logic              wb_load, wb_bubble, wb_from_lat;
  logic [DATA_W-1:0] wb_rd, wb_alu;
  logic [WN_W-1:0]   wb_wn;

  assign acc      = MemRead_in | MemWrite_in;
  assign conflict = MemRead_in & MemWrite_in;

`ifdef ALIGN_CHECK_EN
  assign misaligned = |ALU_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign issue     = (state == ST_IDLE) && acc && !misaligned;
  assign align_err = (state == ST_IDLE) && acc && misaligned;
  assign done      = (state == ST_BUSY) && mem_ack;
  assign abort     = (state == ST_BUSY) && !mem_ack && (count == TO_LAST);

  // NOTE: synchronous reset clears every register here; there are no memory arrays
  // in this block, so nothing is exempt from reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_BUSY) && !mem_ack && !abort) count <= count + 1'b1;
      else                                          count <= '0;
    end
  end

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (issue)          state_nxt = ST_BUSY;
      ST_BUSY: if (done || abort)  state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // While waiting for ack the MEM/WB register holds the bubble taken at issue.
  always_comb begin
    stall       = 1'b0;
    wb_load     = 1'b1;
    wb_bubble   = 1'b0;
    wb_from_lat = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (acc) begin
          wb_bubble = 1'b1;
          stall     = !misaligned;
        end
      end
      ST_BUSY: begin
        stall = !mem_ack && !abort;
        if (mem_ack)    wb_from_lat = 1'b1;
        else if (abort) wb_bubble   = 1'b1;
        else            wb_load     = 1'b0;
      end
      default: ;
    endcase
  end

  // Conflicting MemRead&MemWrite is issued as a write and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_err   <= 1'b0;
      lat_ctrl  <= WB_CTRL_BUBBLE;
      lat_wn    <= '0;
      lat_read  <= 1'b0;
    end else begin
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWrite_in;
        mem_addr  <= ALU_in;
        mem_wdata <= RD2_in;
        lat_ctrl  <= in_ctrl;
        lat_wn    <= WN_in;
        lat_read  <= !MemWrite_in;
      end else if (done || abort) begin
        mem_req <= 1'b0;
      end
      if ((issue && conflict) || abort || align_err) mem_err <= 1'b1;
    end
  end

  assign in_ctrl.reg_write  = RegWrite_in;
  assign in_ctrl.mem_to_reg = MemtoReg_in;

  assign wb_ctrl = wb_from_lat ? lat_ctrl : in_ctrl;
  assign wb_alu  = wb_from_lat ? mem_addr : ALU_in;
  assign wb_wn   = wb_from_lat ? lat_wn   : WN_in;
  assign wb_rd   = (wb_from_lat && lat_read) ? mem_rdata : '0;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .WN_W   (WN_W)
  ) u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (wb_load),
    .bubble       (wb_bubble),
    .ctrl_in      (wb_ctrl),
    .rd_in        (wb_rd),
    .alu_in       (wb_alu),
    .wn_in        (wb_wn),
    .RegWrite_out (RegWrite_out),
    .MemtoReg_out (MemtoReg_out),
    .RD_out       (RD_out),
    .ALU_out      (ALU_out),
    .WN_out       (WN_out)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl: table of pass-through vectors plus
// hand-written load/store/timeout/reset sequences. Honours `ALIGN_CHECK_EN.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
  logic [31:0] ALU_in, RD2_in;
  logic [4:0]  WN_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall, mem_err;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] RD_out, ALU_out;
  logic [4:0]  WN_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .RegWrite_in  (RegWrite_in),
    .MemtoReg_in  (MemtoReg_in),
    .ALU_in       (ALU_in),
    .RD2_in       (RD2_in),
    .WN_in        (WN_in),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .stall        (stall),
    .mem_err      (mem_err),
    .RegWrite_out (RegWrite_out),
    .MemtoReg_out (MemtoReg_out),
    .RD_out       (RD_out),
    .ALU_out      (ALU_out),
    .WN_out       (WN_out)
  );

  typedef struct {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  wn;
    logic        exp_reg_write;
    logic        exp_mem_to_reg;
    logic [31:0] exp_alu;
    logic [4:0]  exp_wn;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic mw, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wn);
    MemRead_in  = mr;
    MemWrite_in = mw;
    RegWrite_in = rw;
    MemtoReg_in = m2r;
    ALU_in      = alu;
    RD2_in      = rd2;
    WN_in       = wn;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stalls;
    int k;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         5'd5,  1'b1, 1'b0, 32'h0000_0010, 5'd5};
    vecs[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 5'd31, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd31};
    vecs[2] = '{1'b1, 1'b1, 32'hA5A5_5A5A, 32'h0,         5'd0,  1'b1, 1'b1, 32'hA5A5_5A5A, 5'd0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 5'd17, 1'b1, 1'b0, 32'h0000_0000, 5'd17};

    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset mem_req",      mem_req,      1'b0);
    check("reset mem_we",       mem_we,       1'b0);
    check("reset mem_addr",     mem_addr,     32'h0);
    check("reset mem_wdata",    mem_wdata,    32'h0);
    check("reset mem_err",      mem_err,      1'b0);
    check("reset RegWrite_out", RegWrite_out, 1'b0);
    check("reset ALU_out",      ALU_out,      32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Non-memory instructions: one-cycle pass-through, no stall.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(0, 0, vecs[i].reg_write, vecs[i].mem_to_reg, vecs[i].alu, vecs[i].rd2, vecs[i].wn);
      #1 check($sformatf("vec%0d stall", i), stall, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d RegWrite_out", i), RegWrite_out, vecs[i].exp_reg_write);
      check($sformatf("vec%0d MemtoReg_out", i), MemtoReg_out, vecs[i].exp_mem_to_reg);
      check($sformatf("vec%0d ALU_out", i),      ALU_out,      vecs[i].exp_alu);
      check($sformatf("vec%0d WN_out", i),       WN_out,       vecs[i].exp_wn);
      check($sformatf("vec%0d RD_out", i),       RD_out,       32'h0);
      check($sformatf("vec%0d mem_req", i),      mem_req,      1'b0);
    end

    // Load, ack arrives on the fourth BUSY cycle: four stall cycles.
    stalls = 0;
    @(negedge clk);
    drive(1, 0, 1, 1, 32'h40, 32'h0, 5'd3);
    #1 if (stall) stalls++;
    @(posedge clk);
    #1;
    check("load mem_req",     mem_req,      1'b1);
    check("load mem_we",      mem_we,       1'b0);
    check("load mem_addr",    mem_addr,     32'h40);
    check("load bubble",      RegWrite_out, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      mem_ack   = (c == 4);
      mem_rdata = (c == 4) ? 32'hCAFE_0001 : 32'h0;
      #1 if (stall) stalls++;
      @(posedge clk);
      #1;
      if (c < 4) check($sformatf("load hold req c%0d", c), mem_req, 1'b1);
    end
    mem_ack = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    check("load stall cycles", stalls,       4);
    check("load RD_out",       RD_out,       32'hCAFE_0001);
    check("load MemtoReg_out", MemtoReg_out, 1'b1);
    check("load RegWrite_out", RegWrite_out, 1'b1);
    check("load ALU_out",      ALU_out,      32'h40);
    check("load WN_out",       WN_out,       5'd3);
    check("load req dropped",  mem_req,      1'b0);

    // Store, ack on first BUSY cycle: one stall cycle, RD_out forced to zero.
    stalls = 0;
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h8, 32'h55, 5'd0);
    #1 if (stall) stalls++;
    @(posedge clk);
    #1;
    check("store mem_we",    mem_we,    1'b1);
    check("store mem_wdata", mem_wdata, 32'h55);
    check("store mem_addr",  mem_addr,  32'h8);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1 if (stall) stalls++;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    check("store stall cycles", stalls,  1);
    check("store RD_out",       RD_out,  32'h0);
    check("store req dropped",  mem_req, 1'b0);

    // Load with no ack: abort after 16 BUSY cycles.
    @(negedge clk);
    drive(1, 0, 1, 1, 32'h100, 32'h0, 5'd9);
    @(posedge clk);
    #1;
    check("to mem_req",     mem_req, 1'b1);
    check("to err clear",   mem_err, 1'b0);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      #1 check($sformatf("to stall c%0d", c), stall, (c < 16));
      @(posedge clk);
      #1;
      if (!mem_req) begin
        k = c;
        break;
      end
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    check("to busy cycles",   k,            16);
    check("to mem_err",       mem_err,      1'b1);
    check("to RegWrite_out",  RegWrite_out, 1'b0);
    @(negedge clk);
    drive(0, 0, 1, 0, 32'h77, 32'h0, 5'd4);
    #1 check("to stall released", stall, 1'b0);
    @(posedge clk);
    #1;
    check("to next passthru", ALU_out, 32'h77);
    check("to err sticky",    mem_err, 1'b1);

    // Reset in the second BUSY cycle, late ack afterwards.
    @(negedge clk);
    drive(1, 0, 1, 1, 32'h20, 32'h0, 5'd7);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    @(posedge clk);
    #1;
    check("rst mem_req",      mem_req,      1'b0);
    check("rst mem_err",      mem_err,      1'b0);
    check("rst mem_addr",     mem_addr,     32'h0);
    check("rst RegWrite_out", RegWrite_out, 1'b0);
    @(negedge clk);
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBEEF_0000;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("late ack RD_out",   RD_out,       32'h0);
    check("late ack RegWrite", RegWrite_out, 1'b0);
    check("late ack WN_out",   WN_out,       5'd0);
    check("late ack mem_req",  mem_req,      1'b0);

    // Ack in IDLE alongside a non-memory instruction is ignored.
    @(negedge clk);
    drive(0, 0, 1, 0, 32'h44, 32'h0, 5'd2);
    mem_ack   = 1'b1;
    mem_rdata = 32'hABCD;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("idle ack RD_out",  RD_out,  32'h0);
    check("idle ack ALU_out", ALU_out, 32'h44);
    check("idle ack mem_req", mem_req, 1'b0);

    // MemRead & MemWrite together: issued as a write, error flagged.
    @(negedge clk);
    drive(1, 1, 0, 0, 32'h30, 32'h77, 5'd0);
    @(posedge clk);
    #1;
    check("conflict mem_we",  mem_we,  1'b1);
    check("conflict mem_err", mem_err, 1'b1);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    check("conflict RD_out", RD_out, 32'h0);

    do_reset();
    check("align pre err", mem_err, 1'b0);
    @(negedge clk);
    drive(1, 0, 1, 1, 32'h6, 32'h0, 5'd1);
`ifdef ALIGN_CHECK_EN
    #1 check("align stall", stall, 1'b0);
    @(posedge clk);
    #1;
    check("align mem_req",  mem_req,      1'b0);
    check("align mem_err",  mem_err,      1'b1);
    check("align bubble",   RegWrite_out, 1'b0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
`else
    #1 check("unaligned stall", stall, 1'b1);
    @(posedge clk);
    #1;
    check("unaligned mem_req",  mem_req,  1'b1);
    check("unaligned mem_addr", mem_addr, 32'h6);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0606;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    check("unaligned RD_out",  RD_out,  32'h0000_0606);
    check("unaligned mem_err", mem_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
